// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run/stop/single-step controller.
//   run_state_t : controller state encoding, also driven out on STATE
//   PRESC_W     : run-rate prescaler width
//   rate_mask() : low-bit mask selecting the prescaler bits compared for a RATE
package run_ctrl_pkg;

    localparam int PRESC_W = 16;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BRK  = 2'd3
    } run_state_t;

    // RATE=0 gives an empty mask, so the compare is true on every CLK.
    function automatic logic [PRESC_W-1:0] rate_mask(input logic [3:0] rate);
        logic [PRESC_W:0] m;
        m = ((PRESC_W+1)'(1) << rate) - (PRESC_W+1)'(1);
        return m[PRESC_W-1:0];
    endfunction

endpackage

// File: rtl/run_step_ctrl_debounce.sv
// Button debouncer: two-flop synchroniser, TICK-sampled level filter and a
// rising-edge press pulse.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   tick  : one-clk sampling strobe
//   raw   : raw button level, asynchronous to clk
//   press : one-clk pulse when a new high level is accepted
module btn_debounce #(
    parameter int DEB_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEB_TICKS + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (tick) begin
                // Any sample agreeing with the accepted level restarts the run.
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_TICKS - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                    press <= sync[1];
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/run_step_ctrl.sv
// Run/stop/single-step controller driving the computer clock enable.
//   CLK, RESET          : clock, asynchronous active-high reset
//   TICK                : debounce sampling strobe
//   BTN_RUN/STOP/STEP   : raw front-panel buttons
//   RATE                : free-run rate, one CEN per 2^RATE CLKs
//   BRK_EN, BRK_ADDR    : address breakpoint
//   ADDR                : current CPU fetch address
//   CEN                 : registered one-CLK clock-enable pulses
//   STATE, HALTED       : controller state, breakpoint halt flag
//   CYCLES              : number of CEN pulses issued (wrapping)
module run_step_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DEB_TICKS = 4,
    parameter int AW        = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          TICK,
    input  logic          BTN_RUN,
    input  logic          BTN_STOP,
    input  logic          BTN_STEP,
    input  logic [3:0]    RATE,
    input  logic          BRK_EN,
    input  logic [AW-1:0] BRK_ADDR,
    input  logic [AW-1:0] ADDR,
    output logic          CEN,
    output logic [1:0]    STATE,
    output logic          HALTED,
    output logic [31:0]   CYCLES
);

    logic press_run, press_stop, press_step;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_run (
        .clk(CLK), .rst(RESET), .tick(TICK), .raw(BTN_RUN), .press(press_run)
    );
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_stop (
        .clk(CLK), .rst(RESET), .tick(TICK), .raw(BTN_STOP), .press(press_stop)
    );
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_step (
        .clk(CLK), .rst(RESET), .tick(TICK), .raw(BTN_STEP), .press(press_step)
    );

    run_state_t         state, state_nx;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] mask;
    logic               rate_hit;
    logic               cen_last;   // CEN was high last CLK: ADDR is freshly updated
    logic               brk_mask;
    logic               hit;
    logic               cen_nx, presc_clr, mask_set;

    assign mask     = rate_mask(RATE);
    assign rate_hit = (presc & mask) == mask;

    // Only a freshly fetched address can hit, so entering RUN while sitting
    // on the breakpoint cannot halt before the first CEN. CEN is registered:
    // at RATE=0 the enable already issued for the hit cycle still goes out.
    assign hit = BRK_EN && cen_last && !brk_mask && (ADDR == BRK_ADDR);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_STOP;
        else       state <= state_nx;
    end

    // Press priority everywhere: STOP > STEP > RUN.
    always_comb begin
        state_nx  = state;
        cen_nx    = 1'b0;
        presc_clr = 1'b0;
        mask_set  = 1'b0;
        case (state)
            ST_STOP: begin
                if (press_stop) begin
                    state_nx = ST_STOP;
                end else if (press_step) begin
                    state_nx = ST_STEP;
                    cen_nx   = 1'b1;     // the single step pulse lands in the STEP cycle
                end else if (press_run) begin
                    state_nx  = ST_RUN;
                    presc_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (press_stop || press_step) begin
                    state_nx = ST_STOP;
                end else if (hit) begin
                    state_nx = ST_BRK;
                end else begin
                    cen_nx = rate_hit;
                end
            end
            ST_STEP: begin
                state_nx = ST_STOP;      // presses arriving here are dropped
            end
            ST_BRK: begin
                if (press_stop) begin
                    state_nx = ST_STOP;
                end else if (press_step) begin
                    state_nx = ST_STEP;
                    cen_nx   = 1'b1;
                end else if (press_run) begin
                    state_nx = ST_RUN;
                    mask_set = 1'b1;
                end
            end
            default: state_nx = ST_STOP;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CEN      <= 1'b0;
            cen_last <= 1'b0;
            presc    <= '0;
            brk_mask <= 1'b0;
            CYCLES   <= '0;
        end else begin
            CEN      <= cen_nx;
            cen_last <= CEN;
            // Prescaler advances every RUN CLK, so each value is compared once.
            if (presc_clr)
                presc <= '0;
            else if (state == ST_RUN)
                presc <= presc + PRESC_W'(1);
            if (mask_set)
                brk_mask <= 1'b1;
            else if (CEN)
                brk_mask <= 1'b0;
            if (CEN)
                CYCLES <= CYCLES + 32'd1;
        end
    end

    assign STATE  = state;
    assign HALTED = (state == ST_BRK);

endmodule

// File: tb/tb_run_step_ctrl.sv
module tb_run_step_ctrl;

    logic        CLK = 1'b0;
    logic        RESET, TICK, BTN_RUN, BTN_STOP, BTN_STEP, BRK_EN;
    logic [3:0]  RATE;
    logic [31:0] BRK_ADDR, ADDR;
    logic        CEN, HALTED;
    logic [1:0]  STATE;
    logic [31:0] CYCLES;

    run_step_ctrl #(.DEB_TICKS(4), .AW(32)) dut (
        .CLK(CLK), .RESET(RESET), .TICK(TICK),
        .BTN_RUN(BTN_RUN), .BTN_STOP(BTN_STOP), .BTN_STEP(BTN_STEP),
        .RATE(RATE), .BRK_EN(BRK_EN), .BRK_ADDR(BRK_ADDR), .ADDR(ADDR),
        .CEN(CEN), .STATE(STATE), .HALTED(HALTED), .CYCLES(CYCLES)
    );

    always #5 CLK = ~CLK;

    int   checks = 0;
    int   errors = 0;
    int   cen_cnt = 0;     // CEN pulses observed since last reset
    int   tick_ph = 0;
    logic cen_s;

    typedef struct {
        logic [3:0] rate;
        int         exp_cnt;    // pulses in the first 64 RUN cycles
        int         exp_first;  // RUN cycle index of the first pulse
    } rate_vec_t;

    rate_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One CLK: sample CEN mid-cycle, then after the edge advance the CPU
    // address model and the TICK strobe (every 8 CLKs).
    task automatic clk1();
        @(negedge CLK);
        cen_s = CEN;
        if (CEN) cen_cnt++;
        @(posedge CLK);
        #1;
        if (cen_s) ADDR = (ADDR == 32'h13) ? 32'h0C : ADDR + 32'd1;
        tick_ph = (tick_ph + 1) % 8;
        TICK = (tick_ph == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) clk1();
    endtask

    task automatic wait_state(input string name, input logic [1:0] st, input int bound);
        int n;
        n = 0;
        while (STATE !== st && n < bound) begin
            clk1();
            n++;
        end
        check(name, {30'd0, STATE}, {30'd0, st});
    endtask

    initial begin
        int   n0, first, last, bad, ncen;
        logic saw_run;

        vecs[0] = '{4'd0, 63, 1};
        vecs[1] = '{4'd1, 31, 2};
        vecs[2] = '{4'd3, 7, 8};
        vecs[3] = '{4'd4, 3, 16};

        RESET = 1'b1; TICK = 1'b0;
        BTN_RUN = 1'b0; BTN_STOP = 1'b0; BTN_STEP = 1'b0;
        RATE = 4'd0; BRK_EN = 1'b0; BRK_ADDR = 32'h10; ADDR = 32'h0C;
        idle(3);
        check("rst_state", {30'd0, STATE}, 32'd0);
        check("rst_cen", {31'd0, CEN}, 32'd0);
        check("rst_cycles", CYCLES, 32'd0);
        check("rst_halted", {31'd0, HALTED}, 32'd0);
        RESET = 1'b0;

        // Two-TICK glitch must not be accepted
        BTN_RUN = 1'b1;
        idle(16);
        BTN_RUN = 1'b0;
        idle(60);
        check("glitch_state", {30'd0, STATE}, 32'd0);
        check("glitch_cen", 32'(cen_cnt), 32'd0);

        // Rate table: enter RUN from STOP, count pulses, then STOP
        for (int v = 0; v < 4; v++) begin
            RATE = vecs[v].rate;
            BTN_RUN = 1'b1;
            wait_state($sformatf("run_enter_r%0d", vecs[v].rate), 2'd1, 200);
            BTN_RUN = 1'b0;
            first = -1; last = -1; bad = 0; ncen = 0;
            for (int k = 0; k < 64; k++) begin
                clk1();
                if (cen_s) begin
                    if (first < 0) first = k;
                    else if (k - last != (1 << vecs[v].rate)) bad++;
                    last = k;
                    ncen++;
                end
            end
            check($sformatf("rate%0d_count", vecs[v].rate), 32'(ncen), 32'(vecs[v].exp_cnt));
            check($sformatf("rate%0d_first", vecs[v].rate), 32'(first), 32'(vecs[v].exp_first));
            check($sformatf("rate%0d_gaps", vecs[v].rate), 32'(bad), 32'd0);
            check($sformatf("rate%0d_cycles", vecs[v].rate), CYCLES, 32'(cen_cnt));
            BTN_STOP = 1'b1;
            wait_state($sformatf("stop_r%0d", vecs[v].rate), 2'd0, 200);
            BTN_STOP = 1'b0;
            n0 = cen_cnt;
            idle(20);
            check($sformatf("stop_r%0d_no_cen", vecs[v].rate), 32'(cen_cnt - n0), 32'd0);
            check($sformatf("stop_r%0d_frozen", vecs[v].rate), CYCLES, 32'(cen_cnt));
        end

        // STEP press while running only stops
        RATE = 4'd3;
        BTN_RUN = 1'b1;
        wait_state("sir_run", 2'd1, 200);
        BTN_RUN = 1'b0;
        idle(20);
        BTN_STEP = 1'b1;
        wait_state("sir_stop", 2'd0, 200);
        BTN_STEP = 1'b0;
        n0 = cen_cnt;
        idle(70);
        check("sir_no_cen", 32'(cen_cnt - n0), 32'd0);
        check("sir_state", {30'd0, STATE}, 32'd0);

        // Held STEP from STOP: exactly one pulse
        n0 = cen_cnt;
        BTN_STEP = 1'b1;
        wait_state("step_enter", 2'd2, 200);
        idle(100);
        BTN_STEP = 1'b0;
        idle(60);
        check("step_one_pulse", 32'(cen_cnt - n0), 32'd1);
        check("step_cycles", CYCLES, 32'(cen_cnt));
        check("step_state", {30'd0, STATE}, 32'd0);

        // Breakpoint at 0x10 starting from 0x0E, RATE=2
        RATE = 4'd2; BRK_EN = 1'b1; BRK_ADDR = 32'h10; ADDR = 32'h0E;
        n0 = cen_cnt;
        BTN_RUN = 1'b1;
        wait_state("brk_run", 2'd1, 200);
        BTN_RUN = 1'b0;
        wait_state("brk_halt", 2'd3, 300);
        check("brk_addr", ADDR, 32'h10);
        check("brk_halted", {31'd0, HALTED}, 32'd1);
        check("brk_pulses", 32'(cen_cnt - n0), 32'd2);
        n0 = cen_cnt;
        idle(60);
        check("brk_no_cen", 32'(cen_cnt - n0), 32'd0);
        check("brk_hold", {30'd0, STATE}, 32'd3);
        n0 = cen_cnt;
        BTN_RUN = 1'b1;
        wait_state("brk_resume", 2'd1, 200);
        BTN_RUN = 1'b0;
        wait_state("brk_rehalt", 2'd3, 400);
        check("brk_loop_pulses", 32'(cen_cnt - n0), 32'd8);
        check("brk_rehalt_addr", ADDR, 32'h10);
        BTN_STOP = 1'b1;
        wait_state("brk_exit", 2'd0, 200);
        BTN_STOP = 1'b0;
        check("brk_exit_halted", {31'd0, HALTED}, 32'd0);
        BRK_EN = 1'b0;
        idle(60);

        // RUN and STOP pressed together: STOP wins
        n0 = cen_cnt;
        saw_run = 1'b0;
        BTN_RUN = 1'b1;
        BTN_STOP = 1'b1;
        for (int k = 0; k < 80; k++) begin
            clk1();
            if (STATE !== 2'd0) saw_run = 1'b1;
        end
        BTN_RUN = 1'b0;
        BTN_STOP = 1'b0;
        idle(60);
        check("coinc_state", {31'd0, saw_run}, 32'd0);
        check("coinc_no_cen", 32'(cen_cnt - n0), 32'd0);

        // RESET mid-run drops CEN without waiting for an edge
        RATE = 4'd0;
        BTN_RUN = 1'b1;
        wait_state("rst_run_enter", 2'd1, 200);
        BTN_RUN = 1'b0;
        idle(3);
        check("rst_pre_cen", {31'd0, CEN}, 32'd1);
        RESET = 1'b1;
        #1;
        check("rst_async_cen", {31'd0, CEN}, 32'd0);
        check("rst_async_state", {30'd0, STATE}, 32'd0);
        check("rst_async_cycles", CYCLES, 32'd0);
        #1;
        RESET = 1'b0;
        cen_cnt = 0;
        idle(10);
        check("rst_after_cycles", CYCLES, 32'd0);
        check("rst_after_state", {30'd0, STATE}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
